// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared direction type, keycode map and screen bounds.
// Revision : 1.0
// ============================================================================
package tank_pkg;

    typedef enum logic [2:0] {
        UP    = 3'd1,
        RIGHT = 3'd2,
        LEFT  = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef struct packed {
        logic move;
        logic fire;
        dir_t dir;
    } key_t;

    localparam logic [7:0] c_KEY_UP_A   = 8'h1A;
    localparam logic [7:0] c_KEY_UP_B   = 8'h52;
    localparam logic [7:0] c_KEY_DN_A   = 8'h16;
    localparam logic [7:0] c_KEY_DN_B   = 8'h51;
    localparam logic [7:0] c_KEY_LF_A   = 8'h04;
    localparam logic [7:0] c_KEY_LF_B   = 8'h50;
    localparam logic [7:0] c_KEY_RT_A   = 8'h07;
    localparam logic [7:0] c_KEY_RT_B   = 8'h4F;
    localparam logic [7:0] c_KEY_FIRE_A = 8'h2C;
    localparam logic [7:0] c_KEY_FIRE_B = 8'h28;

    localparam int c_X_MAX = 639;
    localparam int c_Y_MAX = 479;

    function automatic key_t decode_key(input logic [7:0] key);
        key_t k;
        k.move = 1'b0;
        k.fire = 1'b0;
        k.dir  = UP;
        case (key)
            c_KEY_UP_A, c_KEY_UP_B:     begin k.move = 1'b1; k.dir = UP;    end
            c_KEY_DN_A, c_KEY_DN_B:     begin k.move = 1'b1; k.dir = DOWN;  end
            c_KEY_LF_A, c_KEY_LF_B:     begin k.move = 1'b1; k.dir = LEFT;  end
            c_KEY_RT_A, c_KEY_RT_B:     begin k.move = 1'b1; k.dir = RIGHT; end
            c_KEY_FIRE_A, c_KEY_FIRE_B: k.fire = 1'b1;
            default:                    ;
        endcase
        return k;
    endfunction

    function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                             input logic signed [11:0] hi);
        if (v < 12'sd0)
            return 10'd0;
        else if (v > hi)
            return hi[9:0];
        else
            return v[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tank_ctrl_multi_bullet_slot.sv
`default_nettype none
// ============================================================================
// Module   : bullet_slot
// Brief    : One bullet: spawn latch, per-tick flight, wall/hit retirement.
// Revision : 1.0
// ============================================================================
module bullet_slot
    import tank_pkg::*;
#(
    parameter int BULLET_STEP = 5,
    parameter int BUL_W       = 8,
    parameter int BUL_H       = 8,
    parameter int X_MAX       = c_X_MAX,
    parameter int Y_MAX       = c_Y_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_spawn,
    input  logic [9:0] i_spawn_x,
    input  logic [9:0] i_spawn_y,
    input  dir_t       i_spawn_dir,
    input  logic       i_hit,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_pix_hit
);

    localparam logic signed [10:0] c_STEP  = 11'(BULLET_STEP);
    localparam logic signed [10:0] c_W_M1  = 11'(BUL_W - 1);
    localparam logic signed [10:0] c_H_M1  = 11'(BUL_H - 1);
    localparam logic signed [10:0] c_X_LIM = 11'(X_MAX);
    localparam logic signed [10:0] c_Y_LIM = 11'(Y_MAX);

    logic              r_active;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    dir_t              r_dir;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic              w_out;

    always_comb begin
        w_nx  = $signed({1'b0, r_x});
        w_ny  = $signed({1'b0, r_y});
        w_out = 1'b0;
        case (r_dir)
            UP:      begin w_ny = w_ny - c_STEP; w_out = (w_ny < 11'sd0) || (w_ny + c_H_M1 > c_Y_LIM); end
            DOWN:    begin w_ny = w_ny + c_STEP; w_out = (w_ny < 11'sd0) || (w_ny + c_H_M1 > c_Y_LIM); end
            LEFT:    begin w_nx = w_nx - c_STEP; w_out = (w_nx < 11'sd0) || (w_nx + c_W_M1 > c_X_LIM); end
            RIGHT:   begin w_nx = w_nx + c_STEP; w_out = (w_nx < 11'sd0) || (w_nx + c_W_M1 > c_X_LIM); end
            default: ;
        endcase
    end

    // Spawn only targets an idle slot, so it never competes with flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_dir    <= UP;
        end else if (i_tick) begin
            if (i_spawn) begin
                r_active <= 1'b1;
                r_x      <= i_spawn_x;
                r_y      <= i_spawn_y;
                r_dir    <= i_spawn_dir;
            end else if (r_active) begin
                if (i_hit || w_out) begin
                    r_active <= 1'b0;
                end else begin
                    r_x <= w_nx[9:0];
                    r_y <= w_ny[9:0];
                end
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_active  = r_active;
    assign o_pix_hit = r_active
                     && ({1'b0, i_draw_x} >= {1'b0, r_x}) && ({1'b0, i_draw_x} <= {1'b0, r_x} + 11'(BUL_W - 1))
                     && ({1'b0, i_draw_y} >= {1'b0, r_y}) && ({1'b0, i_draw_y} <= {1'b0, r_y} + 11'(BUL_H - 1));

endmodule
`default_nettype wire

// File: rtl/tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tank_ctrl_multi
// Brief    : Per-player tank movement, wall blocking and pooled bullets.
// Revision : 1.0
// ============================================================================
module tank_ctrl_multi
    import tank_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int TANK_STEP   = 1,
    parameter int BULLET_STEP = 5,
    parameter int COOLDOWN    = 15,
    parameter int TANK_W      = 32,
    parameter int TANK_H      = 32,
    parameter int BUL_W       = 8,
    parameter int BUL_H       = 8,
    parameter int X_MAX       = c_X_MAX,
    parameter int Y_MAX       = c_Y_MAX
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_clk,
    input  logic [9:0]                 X_Start,
    input  logic [9:0]                 Y_Start,
    input  logic [7:0]                 keycode,
    input  logic                       can_move,
    input  logic [NUM_BULLETS-1:0]     bullet_hit,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    output logic [9:0]                 tank_X,
    output logic [9:0]                 tank_Y,
    output logic [2:0]                 tank_dir,
    output logic [10*NUM_BULLETS-1:0]  bullet_X,
    output logic [10*NUM_BULLETS-1:0]  bullet_Y,
    output logic [NUM_BULLETS-1:0]     bullet_active,
    output logic                       is_shooting,
    output logic                       is_tank,
    output logic                       is_bullet
);

    localparam int                      c_CD_W    = $clog2(COOLDOWN + 2);
    localparam logic [c_CD_W-1:0]       c_CD_LOAD = c_CD_W'(COOLDOWN);
    localparam logic signed [11:0]      c_TSTEP   = 12'(TANK_STEP);
    localparam logic signed [11:0]      c_TX_HI   = 12'(X_MAX - TANK_W + 1);
    localparam logic signed [11:0]      c_TY_HI   = 12'(Y_MAX - TANK_H + 1);
    localparam logic [9:0]              c_OFF_X   = 10'((TANK_W - BUL_W) / 2);
    localparam logic [9:0]              c_OFF_Y   = 10'((TANK_H - BUL_H) / 2);

    logic                     r_frame_q;
    logic                     w_tick;
    logic [9:0]               r_tank_x;
    logic [9:0]               r_tank_y;
    dir_t                     r_tank_dir;
    logic [9:0]               w_next_x;
    logic [9:0]               w_next_y;
    dir_t                     w_next_dir;
    logic signed [11:0]       w_sx;
    logic signed [11:0]       w_sy;
    logic [c_CD_W-1:0]        r_cool;
    logic                     r_shoot;
    key_t                     w_key;
    logic                     w_spawn;
    logic [NUM_BULLETS-1:0]   w_active;
    logic [NUM_BULLETS-1:0]   w_free;
    logic [NUM_BULLETS-1:0]   w_spawn_oh;
    logic [NUM_BULLETS-1:0]   w_slot_hit;
    logic [9:0]               w_spawn_x;
    logic [9:0]               w_spawn_y;

    assign w_tick    = frame_clk & ~r_frame_q;
    assign w_key     = decode_key(keycode);
    assign w_sx      = $signed({2'b00, r_tank_x});
    assign w_sy      = $signed({2'b00, r_tank_y});
    assign w_spawn_x = r_tank_x + c_OFF_X;
    assign w_spawn_y = r_tank_y + c_OFF_Y;

    // Free mask is taken before this tick's retirements; x & -x isolates the lowest free slot.
    assign w_free     = ~w_active;
    assign w_spawn    = w_tick & w_key.fire & (r_cool == '0) & (|w_free);
    assign w_spawn_oh = w_spawn ? (w_free & (~w_free + NUM_BULLETS'(1))) : '0;

    always_comb begin
        w_next_x   = r_tank_x;
        w_next_y   = r_tank_y;
        w_next_dir = r_tank_dir;
        if (w_key.move) begin
            w_next_dir = w_key.dir;
            if (can_move) begin
                case (w_key.dir)
                    UP:      w_next_y = clamp_pos(w_sy - c_TSTEP, c_TY_HI);
                    DOWN:    w_next_y = clamp_pos(w_sy + c_TSTEP, c_TY_HI);
                    LEFT:    w_next_x = clamp_pos(w_sx - c_TSTEP, c_TX_HI);
                    RIGHT:   w_next_x = clamp_pos(w_sx + c_TSTEP, c_TX_HI);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_q  <= 1'b0;
            r_tank_x   <= X_Start;
            r_tank_y   <= Y_Start;
            r_tank_dir <= UP;
            r_cool     <= '0;
            r_shoot    <= 1'b0;
        end else begin
            r_frame_q <= frame_clk;
            r_shoot   <= w_spawn;
            if (w_tick) begin
                r_tank_x   <= w_next_x;
                r_tank_y   <= w_next_y;
                r_tank_dir <= w_next_dir;
                if (w_spawn)
                    r_cool <= c_CD_LOAD;
                else if (r_cool != '0)
                    r_cool <= r_cool - c_CD_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            bullet_slot #(
                .BULLET_STEP (BULLET_STEP),
                .BUL_W       (BUL_W),
                .BUL_H       (BUL_H),
                .X_MAX       (X_MAX),
                .Y_MAX       (Y_MAX)
            ) u_slot (
                .clk         (Clk),
                .rst         (Reset),
                .i_tick      (w_tick),
                .i_spawn     (w_spawn_oh[gi]),
                .i_spawn_x   (w_spawn_x),
                .i_spawn_y   (w_spawn_y),
                .i_spawn_dir (r_tank_dir),
                .i_hit       (bullet_hit[gi]),
                .i_draw_x    (DrawX),
                .i_draw_y    (DrawY),
                .o_x         (bullet_X[10*gi +: 10]),
                .o_y         (bullet_Y[10*gi +: 10]),
                .o_active    (w_active[gi]),
                .o_pix_hit   (w_slot_hit[gi])
            );
        end
    endgenerate

    assign tank_X        = r_tank_x;
    assign tank_Y        = r_tank_y;
    assign tank_dir      = r_tank_dir;
    assign bullet_active = w_active;
    assign is_shooting   = r_shoot;
    assign is_bullet     = |w_slot_hit;
    assign is_tank       = ({1'b0, DrawX} >= {1'b0, r_tank_x}) && ({1'b0, DrawX} <= {1'b0, r_tank_x} + 11'(TANK_W - 1))
                        && ({1'b0, DrawY} >= {1'b0, r_tank_y}) && ({1'b0, DrawY} <= {1'b0, r_tank_y} + 11'(TANK_H - 1));

endmodule
`default_nettype wire

// File: tb/tb_tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_ctrl_multi
// Brief    : Scoreboard bench for tank_ctrl_multi against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_tank_ctrl_multi;

    localparam int NB     = 4;
    localparam int COOL   = 15;
    localparam int TSTEP  = 1;
    localparam int BSTEP  = 5;
    localparam int T_XLIM = 639 - 32 + 1;
    localparam int T_YLIM = 479 - 32 + 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             frame_clk = 1'b0;
    logic [9:0]       X_Start = 10'd0;
    logic [9:0]       Y_Start = 10'd0;
    logic [7:0]       keycode = 8'h00;
    logic             can_move = 1'b0;
    logic [NB-1:0]    bullet_hit = '0;
    logic [9:0]       DrawX = 10'd0;
    logic [9:0]       DrawY = 10'd0;
    logic [9:0]       tank_X, tank_Y;
    logic [2:0]       tank_dir;
    logic [10*NB-1:0] bullet_X, bullet_Y;
    logic [NB-1:0]    bullet_active;
    logic             is_shooting, is_tank, is_bullet;

    always #5 Clk = ~Clk;

    tank_ctrl_multi #(.NUM_BULLETS(NB), .COOLDOWN(COOL)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .X_Start(X_Start), .Y_Start(Y_Start),
        .keycode(keycode), .can_move(can_move), .bullet_hit(bullet_hit), .DrawX(DrawX), .DrawY(DrawY),
        .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir), .bullet_X(bullet_X), .bullet_Y(bullet_Y),
        .bullet_active(bullet_active), .is_shooting(is_shooting), .is_tank(is_tank), .is_bullet(is_bullet)
    );

    typedef struct packed {
        logic [9:0]       tx;
        logic [9:0]       ty;
        logic [2:0]       dir;
        logic [NB-1:0]    act;
        logic [10*NB-1:0] bx;
        logic [10*NB-1:0] by;
        logic             shoot;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   shoot_cnt = 0;
    bit   mon_prev = 0, mon_post = 0, mon_post2 = 0;

    // Frame-level reference state
    int m_x, m_y, m_dir, m_cool;
    bit b_act[NB];
    int b_x[NB], b_y[NB], b_dir[NB];

    logic [7:0] keys[12] = '{8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50,
                             8'h07, 8'h4F, 8'h2C, 8'h28, 8'h00, 8'h2C};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int x, input int y);
        m_x = x; m_y = y; m_dir = 1; m_cool = 0;
        for (int i = 0; i < NB; i++) begin
            b_act[i] = 0; b_x[i] = 0; b_y[i] = 0; b_dir[i] = 1;
        end
    endtask

    task automatic model_tick(input logic [7:0] k, input bit cm, input logic [NB-1:0] hit, output bit shoot);
        int  kdir, free_slot, nx, ny;
        bit  is_move, is_fire, gone;
        kdir = 0; is_move = 0; is_fire = 0; shoot = 0;
        case (k)
            8'h1A, 8'h52: begin is_move = 1; kdir = 1; end
            8'h07, 8'h4F: begin is_move = 1; kdir = 2; end
            8'h04, 8'h50: begin is_move = 1; kdir = 3; end
            8'h16, 8'h51: begin is_move = 1; kdir = 4; end
            8'h2C, 8'h28: is_fire = 1;
            default: ;
        endcase
        free_slot = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (!b_act[i]) free_slot = i;
        for (int i = 0; i < NB; i++) begin
            if (b_act[i]) begin
                if (hit[i]) begin
                    b_act[i] = 0;
                end else begin
                    nx = b_x[i]; ny = b_y[i]; gone = 0;
                    case (b_dir[i])
                        1: begin ny = ny - BSTEP; gone = (ny < 0) || (ny + 7 > 479); end
                        4: begin ny = ny + BSTEP; gone = (ny < 0) || (ny + 7 > 479); end
                        3: begin nx = nx - BSTEP; gone = (nx < 0) || (nx + 7 > 639); end
                        default: begin nx = nx + BSTEP; gone = (nx < 0) || (nx + 7 > 639); end
                    endcase
                    if (gone) b_act[i] = 0;
                    else begin b_x[i] = nx; b_y[i] = ny; end
                end
            end
        end
        if (is_fire && m_cool == 0 && free_slot >= 0) begin
            b_act[free_slot] = 1;
            b_x[free_slot]   = m_x + 12;
            b_y[free_slot]   = m_y + 12;
            b_dir[free_slot] = m_dir;
            shoot  = 1;
            m_cool = COOL;
        end else if (m_cool > 0) begin
            m_cool--;
        end
        if (is_move) begin
            m_dir = kdir;
            if (cm) begin
                case (kdir)
                    1: m_y = (m_y - TSTEP < 0) ? 0 : m_y - TSTEP;
                    4: m_y = (m_y + TSTEP > T_YLIM) ? T_YLIM : m_y + TSTEP;
                    3: m_x = (m_x - TSTEP < 0) ? 0 : m_x - TSTEP;
                    default: m_x = (m_x + TSTEP > T_XLIM) ? T_XLIM : m_x + TSTEP;
                endcase
            end
        end
    endtask

    function automatic exp_t snapshot(input bit shoot);
        exp_t e;
        e.tx = 10'(m_x); e.ty = 10'(m_y); e.dir = 3'(m_dir); e.shoot = shoot;
        for (int i = 0; i < NB; i++) begin
            e.act[i]          = b_act[i];
            e.bx[10*i +: 10]  = 10'(b_x[i]);
            e.by[10*i +: 10]  = 10'(b_y[i]);
        end
        return e;
    endfunction

    task automatic check_pix();
        int t, bx, by, w, v, u;
        bit et, eb;
        t = int'($urandom_range(0, NB));
        if (t == NB) begin bx = m_x; by = m_y; w = 32; end
        else begin bx = b_x[t]; by = b_y[t]; w = 8; end
        v = bx + int'($urandom_range(0, w + 1)) - 1; if (v < 0) v = 0;
        u = by + int'($urandom_range(0, w + 1)) - 1; if (u < 0) u = 0;
        DrawX = 10'(v); DrawY = 10'(u);
        #1;
        et = (v >= m_x) && (v <= m_x + 31) && (u >= m_y) && (u <= m_y + 31);
        eb = 0;
        for (int i = 0; i < NB; i++)
            if (b_act[i] && v >= b_x[i] && v <= b_x[i] + 7 && u >= b_y[i] && u <= b_y[i] + 7) eb = 1;
        check("is_tank", 64'(is_tank), 64'(et));
        check("is_bullet", 64'(is_bullet), 64'(eb));
    endtask

    task automatic do_tick(input logic [7:0] k, input bit cm, input logic [NB-1:0] hit, input int hold);
        bit sh;
        @(negedge Clk);
        keycode = k; can_move = cm; bullet_hit = hit; frame_clk = 1'b1;
        model_tick(k, cm, hit, sh);
        exp_q.push_back(snapshot(sh));
        repeat (hold) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_pix();
    endtask

    task automatic do_reset(input int x, input int y);
        @(negedge Clk);
        X_Start = 10'(x); Y_Start = 10'(y);
        frame_clk = 1'b0; keycode = 8'h00; bullet_hit = '0; Reset = 1'b1;
        model_reset(x, y);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_tank_X", 64'(tank_X), 64'(x));
        check("rst_tank_Y", 64'(tank_Y), 64'(y));
        check("rst_tank_dir", 64'(tank_dir), 64'd1);
        check("rst_bullet_active", 64'(bullet_active), 64'd0);
        check("rst_is_shooting", 64'(is_shooting), 64'd0);
    endtask

    // Monitor: one Clk after each frame_clk rise the DUT presents its post-tick state.
    initial begin
        forever begin
            @(posedge Clk);
            mon_post = frame_clk && !mon_prev && !Reset;
            mon_prev = frame_clk;
            @(negedge Clk);
            if (mon_post2) check("is_shooting_width", 64'(is_shooting), 64'd0);
            mon_post2 = mon_post;
            if (mon_post) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_empty actual=tick expected=queued_entry");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tank_X", 64'(tank_X), 64'(mon_e.tx));
                    check("tank_Y", 64'(tank_Y), 64'(mon_e.ty));
                    check("tank_dir", 64'(tank_dir), 64'(mon_e.dir));
                    check("bullet_active", 64'(bullet_active), 64'(mon_e.act));
                    check("bullet_X", 64'(bullet_X), 64'(mon_e.bx));
                    check("bullet_Y", 64'(bullet_Y), 64'(mon_e.by));
                    check("is_shooting", 64'(is_shooting), 64'(mon_e.shoot));
                    if (is_shooting) shoot_cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc0, k;
        // Scenario 1: move up three frames
        do_reset(100, 200);
        repeat (3) do_tick(8'h1A, 1'b1, '0, 1);
        check("s1_tank_Y", 64'(tank_Y), 64'd197);
        // Scenario 2: blocked turn to the right
        do_reset(100, 200);
        repeat (2) do_tick(8'h07, 1'b0, '0, 2);
        check("s2_tank_X", 64'(tank_X), 64'd100);
        check("s2_tank_dir", 64'(tank_dir), 64'd2);
        // Scenario 3: single shot, then one flight step
        do_reset(100, 200);
        sc0 = shoot_cnt;
        do_tick(8'h2C, 1'b1, '0, 1);
        check("s3_spawn_x", 64'(bullet_X[9:0]), 64'd112);
        check("s3_spawn_y", 64'(bullet_Y[9:0]), 64'd212);
        check("s3_pulses", 64'(shoot_cnt - sc0), 64'd1);
        do_tick(8'h00, 1'b1, '0, 1);
        check("s3_step_y", 64'(bullet_Y[9:0]), 64'd207);
        // Scenario 4: fire held 40 frames
        do_reset(100, 200);
        sc0 = shoot_cnt;
        repeat (40) do_tick(8'h2C, 1'b1, '0, 1);
        check("s4_pulses", 64'(shoot_cnt - sc0), 64'd3);
        check("s4_active", 64'(bullet_active), 64'b0111);
        // Asynchronous reset with three bullets in flight
        @(negedge Clk);
        X_Start = 10'd50; Y_Start = 10'd60;
        #2 Reset = 1'b1;
        #1;
        check("async_rst_active", 64'(bullet_active), 64'd0);
        check("async_rst_tank_X", 64'(tank_X), 64'd50);
        model_reset(50, 60);
        @(negedge Clk);
        Reset = 1'b0;
        // Scenario 5: full pool, hit on slot 1 while fire is held
        do_reset(300, 440);
        repeat (64) do_tick(8'h2C, 1'b1, '0, 1);
        check("s5_full", 64'(bullet_active), 64'b1111);
        sc0 = shoot_cnt;
        do_tick(8'h2C, 1'b1, 4'b0010, 1);
        check("s5_retire", 64'(bullet_active), 64'b1101);
        check("s5_no_pulse", 64'(shoot_cnt - sc0), 64'd0);
        do_tick(8'h2C, 1'b1, '0, 1);
        check("s5_respawn", 64'(bullet_active), 64'b1111);
        check("s5_respawn_y", 64'(bullet_Y[19:10]), 64'd452);
        // Scenario 6: leftward bullet leaving the screen edge
        do_reset(1, 200);
        do_tick(8'h04, 1'b0, '0, 1);
        do_tick(8'h2C, 1'b1, '0, 1);
        repeat (2) do_tick(8'h00, 1'b1, '0, 1);
        check("s6_at_3", 64'(bullet_X[9:0]), 64'd3);
        do_tick(8'h00, 1'b1, '0, 1);
        check("s6_retired", 64'(bullet_active[0]), 64'd0);
        // Randomised play
        do_reset(int'($urandom_range(0, T_XLIM)), int'($urandom_range(0, T_YLIM)));
        for (int n = 0; n < 250; n++) begin
            k = int'($urandom_range(0, 11));
            do_tick(keys[k], 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0,
                    int'($urandom_range(1, 3)));
            if (n == 120) do_reset(int'($urandom_range(0, T_XLIM)), int'($urandom_range(0, T_YLIM)));
        end
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tank_ctrl_multi.md
Name: tank_ctrl_multi

Overview:
- Per-player tank controller: keyboard-driven movement, wall blocking, and a pool of NUM_BULLETS independent bullets with a fire cooldown.
- Sits between the keycode decoder and the sprite/colour mapper; one instance per player.
- Also produces per-pixel is_tank/is_bullet flags for the renderer.

Parameters:
- NUM_BULLETS, 4, bullet pool depth (1..8)
- TANK_STEP, 1, tank pixels per frame
- BULLET_STEP, 5, bullet pixels per frame
- COOLDOWN, 15, frames between shots (0 = every frame)
- TANK_W / TANK_H, 32 / 32, tank size
- BUL_W / BUL_H, 8 / 8, bullet size
- X_MAX / Y_MAX, 639 / 479, last visible pixel

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  ~60 Hz frame strobe (vsync)
- X_Start, Y_Start  in  10 each  spawn position, sampled at reset
- keycode  in  8  current key
- can_move  in  1  low = tank blocked by wall this frame
- bullet_hit  in  NUM_BULLETS  per-slot external hit/retire request
- DrawX, DrawY  in  10 each  current pixel
- tank_X, tank_Y  out  10 each  tank top-left
- tank_dir  out  3  1 = up, 2 = right, 3 = left, 4 = down
- bullet_X, bullet_Y  out  10*NUM_BULLETS each  slot i at bits [10i+9:10i]
- bullet_active  out  NUM_BULLETS  slot in flight
- is_shooting  out  1  one-Clk pulse on the tick a bullet spawns
- is_tank, is_bullet  out  1 each  combinational pixel hit

Behaviour:
- Reset (async) sets:
  - tank_X/Y = X_Start/Y_Start, tank_dir = 1
  - all bullets inactive at (0,0)
  - cooldown counter = 0, is_shooting = 0
  - edge-detect register = 0
- Tick: frame_clk registered once; tick = frame_clk & ~frame_clk_q. All state changes happen only in tick cycles; outputs update the Clk after the tick.
- Keys:
  - up = 1A/52, down = 16/51, left = 04/50, right = 07/4F
  - fire = 2C/28
  - any other value = idle
- Move key:
  - tank_dir is set to that direction even when blocked.
  - Position moves TANK_STEP only if can_move = 1.
  - Result is clamped to [0, X_MAX-TANK_W+1] x [0, Y_MAX-TANK_H+1].
  - No bounce and no momentum: idle or fire key means the position is held.
- Fire key: spawns when cooldown = 0 and at least one slot is inactive (pre-tick mask).
  - Slot chosen = lowest-index inactive slot.
  - Spawn position = (tank_X+(TANK_W-BUL_W)/2, tank_Y+(TANK_H-BUL_H)/2).
  - Slot direction = tank_dir latched per slot.
  - Cooldown loads COOLDOWN; is_shooting pulses.
  - Holding fire repeats every COOLDOWN+1 ticks.
  - With no free slot: no spawn, no pulse, cooldown unchanged.
- Cooldown decrements by 1 each tick while nonzero.
- Active slot each tick:
  - If bullet_hit[i] = 1: retire (active = 0, position held).
  - Otherwise compute the next position in 11-bit signed. If next < 0 or next+BUL-1 > MAX on the moving axis: retire. Else move BULLET_STEP.
  - bullet_hit on an inactive slot is ignored.
  - A slot retiring this tick is not reusable until the next tick.
- A newly spawned bullet does not move on its spawn tick.
- Pixel flags (combinational):
  - is_tank = DrawX in [tank_X, tank_X+TANK_W-1] and DrawY in [tank_Y, tank_Y+TANK_H-1]. Bounds are exclusive of +W.
  - is_bullet = OR over active slots of the same test with BUL_W/BUL_H.
- Reset mid-flight clears every slot immediately, regardless of Clk.

Decomposition:
- Package tank_pkg:
  - dir_t enum (UP = 1, RIGHT = 2, LEFT = 3, DOWN = 4)
  - keycode localparams
  - screen-bound constants
- Sub-module bullet_slot (one per slot, generate loop):
  - holds active, x, y, dir
  - inputs: tick, spawn, spawn_x/y/dir, hit
  - outputs: position, active, pixel hit
- Top level contains the edge detect, tank movement, allocator/priority encoder, and cooldown counter.

Test Plan:
1. Reset with Start = (100,200) -> tank (100,200), dir 1, bullet_active = 0000; then 3 ticks with keycode 1A, can_move = 1 -> tank_Y = 197, dir 1.
2. Tank (100,200), dir 2, key 07, can_move = 0 for 2 ticks -> position (100,200) unchanged, dir 2.
3. Tank (100,200), dir 1, fire key for 1 tick -> slot0 active at (112,212), is_shooting one Clk; next tick -> slot0 at (112,207).
4. COOLDOWN = 15, fire held 40 ticks, NUM_BULLETS = 4 -> spawns on ticks 0, 16, 32 into slots 0, 1, 2; slot3 stays inactive.
5. All 4 slots active, fire held, cooldown 0, bullet_hit = 0010 on the same tick -> no spawn that tick, slot1 retires; next tick -> slot1 spawns.
6. Bullet moving left at x = 3 -> retires on the next tick (next = -2). Assert Reset asynchronously mid-frame with 3 bullets active -> bullet_active = 0000 before the next Clk edge.
